// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by its consumer: strobe out, empty flag and registered data in.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // reader side (the UART transmitter)
  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_rdata
  );

  // storage side (the FIFO)
  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_rdata
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the last one.
// Shared between the transmitter and the future receiver.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up and wrap at the end of the period
  always_comb begin
    bit_end_o = enable_i && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and sends it as 8N1, LSB first.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              frame_done_q, frame_done_d;
  logic              timer_en;
  logic              bit_end;

  // timer runs only while a bit is on the wire and restarts from zero otherwise
  assign timer_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!timer_en),
    .enable_i (timer_en),
    .bit_end_o(bit_end)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; tx_en only matters in IDLE so a started frame always finishes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_en && !fifo.fifo_empty) state_d = POP;
      POP:     state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == IDX_LAST)) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output/datapath next values; tx_d is the level the line shows next cycle
  always_comb begin
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = tx_q;
    fifo_rd_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = TX_IDLE;
        fifo_rd_d = (state_d == POP);
      end
      POP: begin
        tx_d = TX_IDLE;
      end
      LOAD: begin
        shift_d   = fifo.fifo_rdata;
        bit_idx_d = '0;
        tx_d      = START_BIT;
      end
      START: begin
        if (bit_end) tx_d = shift_q[0];
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          tx_d      = (bit_idx_q == IDX_LAST) ? STOP_BIT : shift_q[1];
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_d         = TX_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        tx_d = TX_IDLE;
      end
    endcase
  end

  // datapath and registered outputs; reset drops any popped but unsent byte
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      bit_idx_q    <= '0;
      tx_q         <= TX_IDLE;
      fifo_rd_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      fifo_rd_q    <= fifo_rd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx           = tx_q;
  assign fifo.fifo_rd = fifo_rd_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a byte-queue FIFO model feeds the DUT, every cycle is logged,
// and the log is compared against a frame-level timing model of the transmitter.
module tb_fifo_uart_tx;
  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int FRAME  = (DATA_W + 2) * CPB;
  localparam int MAXC   = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_en = 1'b0;
  logic tx, busy, frame_done;

  fifo_uart_tx_if #(.DATA_W(DATA_W)) fifo_bus ();

  fifo_uart_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_en     (tx_en),
    .fifo      (fifo_bus),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes from the stimulus, pops on the read strobe, data registered
  logic [7:0] fifo_mem [0:255];
  int push_cnt = 0;
  int pop_cnt = 0;
  int rd_while_empty = 0;
  assign fifo_bus.fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_bus.fifo_rd) begin
      if (push_cnt == pop_cnt) begin
        rd_while_empty <= rd_while_empty + 1;
      end else begin
        fifo_bus.fifo_rdata <= fifo_mem[pop_cnt];
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // per-cycle log: outputs packed as {tx, fifo_rd, busy, frame_done}
  logic [3:0] obs_a [MAXC];
  bit en_a [MAXC];
  bit rst_a [MAXC];
  int ncyc = 0;
  logic [7:0] snap_q [$];
  int pop0 = 0;

  task automatic tick();
    if (ncyc < MAXC) begin
      obs_a[ncyc] = {tx, fifo_bus.fifo_rd, busy, frame_done};
      en_a[ncyc]  = tx_en;
      rst_a[ncyc] = reset;
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic begin_scn();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    ncyc = 0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[push_cnt] = b;
    push_cnt++;
  endtask

  task automatic snap();
    snap_q.delete();
    for (int i = pop_cnt; i < push_cnt; i++) snap_q.push_back(fifo_mem[i]);
    pop0 = pop_cnt;
  endtask

  function automatic int find_rd(input int from, input int nth);
    int seen;
    seen = 0;
    for (int k = from; k < ncyc; k++) begin
      if (obs_a[k][2]) begin
        seen++;
        if (seen == nth) return k;
      end
    end
    return -1;
  endfunction

  function automatic int count_bit(input int pos, input int from, input int to);
    int c;
    c = 0;
    for (int k = from; k < to && k < ncyc; k++) if (obs_a[k][pos]) c++;
    return c;
  endfunction

  // Frame-level model. A frame starts in an IDLE cycle T0 where tx_en is high and the
  // FIFO holds data; relative to T0: strobe at +1, start bit from +3, each bit CPB cycles,
  // stop bit ends at +42, frame_done in the IDLE cycle +43 (which may start the next frame).
  task automatic eval_scn(input string name);
    logic [7:0] q [$];
    logic [7:0] cur;
    logic [3:0] e;
    logic       txv;
    bit active, fd;
    int t0, off, bi, pops;
    q = snap_q;
    active = 0; fd = 0; t0 = 0; pops = 0; cur = 8'h00;
    for (int k = 0; k < ncyc; k++) begin
      off = k - t0;
      if (active) begin
        if (off < 3) txv = 1'b1;
        else begin
          bi = (off - 3) / CPB;
          if (bi == 0) txv = 1'b0;
          else if (bi <= DATA_W) txv = cur[bi-1];
          else txv = 1'b1;
        end
        e = {txv, (off == 1), 1'b1, 1'b0};
      end else begin
        e = {1'b1, 1'b0, 1'b0, fd};
      end
      check($sformatf("%s.c%0d", name, k), int'(obs_a[k]), int'(e));
      if (rst_a[k]) begin
        active = 0;
        fd = 0;
      end else if (active) begin
        fd = 0;
        if (off == FRAME + 2) begin
          active = 0;
          fd = 1;
        end
      end else begin
        fd = 0;
        if (en_a[k] && q.size() > 0) begin
          active = 1;
          t0 = k;
          cur = q.pop_front();
          if (k <= ncyc - 2) pops++;
        end
      end
    end
    check({name, ".pops"}, pop_cnt - pop0, pops);
  endtask

  initial begin
    int r, r1, r2;
    #1;

    // reset held 3 cycles with data waiting, then one 0xA5 frame
    begin_scn();
    push(8'hA5);
    snap();
    tx_en = 1'b1;
    ticks(3);
    reset = 1'b0;
    ticks(50);
    eval_scn("a5");
    check("a5.rd_pos_after_release", find_rd(3, 1) - 3 + 1, 2);
    check("a5.rd_count", count_bit(2, 0, ncyc), 1);
    check("a5.fd_count", count_bit(0, 0, ncyc), 1);

    // back-to-back 0x00 then 0xFF
    begin_scn();
    push(8'h00);
    push(8'hFF);
    snap();
    tx_en = 1'b1;
    tick();
    reset = 1'b0;
    ticks(100);
    eval_scn("b2b");
    r1 = find_rd(0, 1);
    r2 = find_rd(0, 2);
    check("b2b.rd_gap", r2 - r1, FRAME + 3);

    // tx_en dropped mid-DATA with two more bytes queued
    begin_scn();
    push(8'h3C);
    push(8'h81);
    push(8'h5A);
    snap();
    tx_en = 1'b1;
    tick();
    reset = 1'b0;
    ticks(20);
    tx_en = 1'b0;
    ticks(70);
    r = ncyc;
    tx_en = 1'b1;
    ticks(100);
    eval_scn("en_drop");
    check("en_drop.rd_while_off", count_bit(2, 2, r), 1);
    check("en_drop.fd_while_off", count_bit(0, 0, r), 1);
    check("en_drop.rd_pos_after_reen", find_rd(r, 1) - r + 1, 2);

    // reset pulsed during DATA bit 3; next byte must still go out intact
    begin_scn();
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    snap();
    tx_en = 1'b1;
    tick();
    reset = 1'b0;
    ticks(20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(100);
    eval_scn("mid_rst");
    check("mid_rst.tx_after", int'(obs_a[22][3]), 1);
    check("mid_rst.busy_after", int'(obs_a[22][1]), 0);
    check("mid_rst.fd_aborted", count_bit(0, 0, 23), 0);

    // empty FIFO with tx_en held high
    begin_scn();
    snap();
    tx_en = 1'b1;
    tick();
    reset = 1'b0;
    ticks(100);
    eval_scn("empty");
    check("empty.rd_count", count_bit(2, 0, ncyc), 0);
    check("empty.busy_count", count_bit(1, 0, ncyc), 0);

    // randomized tx_en / reset activity over random bytes
    for (int round = 0; round < 3; round++) begin
      begin_scn();
      for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
      snap();
      tx_en = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 29) == 0) tx_en = ~tx_en;
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      reset = 1'b0;
      eval_scn($sformatf("rand%0d", round));
    end

    check("rd_while_empty", rd_while_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Consumer end of the synchronous 8x8 FIFO.
- Pops bytes through the FIFO's read port (read strobe, empty flag, registered read data) and serialises each byte as an 8N1 UART frame on a single line.
- Sits between the FIFO and the board TX pin. Closes the write-to-FIFO-to-wire path.

Parameters:
- DATA_W, 8, data bits per frame; equals the FIFO word width.
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- tx_en  in  1  permits starting new frames; a frame in progress always completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_W  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  FIFO read strobe; one-cycle pulse per byte.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after each frame's stop bit.

Behaviour:
- Interface (already decided): reset is synchronous, active-high; the clock is clk.
- Reset values: tx=1, fifo_rd=0, busy=0, frame_done=0, state=IDLE, counters=0.
- tx and fifo_rd are registered outputs.
- States and transitions:
  - IDLE: if tx_en && !fifo_empty, go to POP; otherwise stay.
  - POP: 1 cycle, fifo_rd=1. Go to LOAD.
  - LOAD: 1 cycle. Capture fifo_rdata into the shift register; tx<=0 at the end of this cycle. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. Shift right on each bit boundary. Go to STOP after bit DATA_W-1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Go to IDLE.
- Timing: if cycle T0 is IDLE with the start condition true:
  - fifo_rd is high in T1.
  - Data is captured at the end of T2.
  - tx first reads 0 in T3.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles.
- frame_done is high in the first IDLE cycle after STOP.
- Back-to-back frames: IDLE re-evaluates in that same first cycle. The gap between frames is therefore exactly 3 tx-high cycles (IDLE, POP, LOAD) beyond the stop bit.
- Pop discipline:
  - fifo_rd is never asserted while fifo_empty=1.
  - Exactly one fifo_rd per transmitted frame.
  - This block is the sole reader of the FIFO, so a non-empty FIFO seen in IDLE stays non-empty through POP.
- tx_en:
  - Sampled only in IDLE.
  - Deassertion mid-frame has no effect on the current frame.
  - Deassertion during POP/LOAD still transmits the popped byte.
- Reset mid-operation:
  - Next cycle: tx=1, busy=0, fifo_rd=0.
  - A popped but unsent byte is discarded.
  - No frame_done pulse for the aborted frame.
- Widths:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index: $clog2(DATA_W) bits, wraps 7->0 on leaving DATA.
  - No other arithmetic.

Decomposition:
- Shared package (uart_pkg):
  - State enum: IDLE, POP, LOAD, START, DATA, STOP.
  - Constants TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, uart_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear, enable.
  - Output: bit_end pulse on the last cycle of each bit period.
  - Reused later by the receiver.

Test Plan (CLKS_PER_BIT=4, DATA_W=8):
- Reset held 3 cycles, FIFO holding data, tx_en=1 -> tx=1, fifo_rd=0, busy=0, frame_done=0 throughout; first fifo_rd pulse is exactly 2 cycles after reset falls (IDLE then POP).
- FIFO holds 0xA5, tx_en=1 -> one fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); frame_done pulses once, 1 cycle after the stop bit ends.
- FIFO holds 0x00 then 0xFF -> two fifo_rd pulses 43 cycles apart; data bits all-0 then all-1; exactly 3 high cycles between the first stop bit's end and the second start bit.
- tx_en dropped in the middle of DATA with 2 bytes queued -> current frame completes with frame_done; no further fifo_rd while tx_en=0; re-asserting tx_en produces fifo_rd 2 cycles later.
- reset pulsed during DATA bit 3 -> tx=1 and busy=0 the next cycle; no frame_done; after release the next queued byte is popped and sent intact.
- FIFO empty, tx_en=1 for 100 cycles -> fifo_rd never asserted, tx constant 1, busy 0.
